// File: rtl/mem_request_controller.sv
// mem_request_controller: round-robin arbiter that funnels per-lane data-memory
// read/write requests onto a single external memory port, one transaction at a
// time, and relays exactly one ready back to the requesting lane.
//
// Handshake: a requester raises valid with stable address (and data) and holds
// it until the matching ready is seen high. A ready is asserted once per
// request and stays high until the requester drops valid. The external port
// uses the same rules: mem_*_valid is held stable until mem_*_ready is seen
// high at a clock edge.
module mem_request_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,
  output logic                     mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address,
  output logic [DATA_BITS-1:0]     mem_write_data,
  input  logic                     mem_write_ready,
  output logic [1:0]               debug_state,
  output logic [PTR_W-1:0]         debug_rr_ptr
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_t;

  state_t                   state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         grant;
  logic                     served_write;

  logic [NUM_CONSUMERS-1:0] pending;
  logic                     found;
  logic [PTR_W-1:0]         pick;
  logic [PTR_W-1:0]         rr_next;
  int                       idx;

  assign pending      = consumer_read_valid | consumer_write_valid;
  assign debug_state  = state;
  assign debug_rr_ptr = rr_ptr;

  // Round-robin search for the first pending lane starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CONSUMERS;
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
    rr_next = (pick == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : pick + 1'b1;
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant                <= '0;
      served_write         <= 1'b0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        consumer_read_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= pick;
            rr_ptr <= rr_next;
            // Read wins when a lane asks for both; its write waits for a later grant.
            if (consumer_read_valid[pick]) begin
              served_write     <= 1'b0;
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[pick];
              state            <= READ_WAIT;
            end else begin
              served_write      <= 1'b1;
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[pick];
              mem_write_data    <= consumer_write_data[pick];
              state             <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid             <= 1'b0;
            consumer_read_data[grant]  <= mem_read_data;
            consumer_read_ready[grant] <= 1'b1;
            state                      <= RELAY;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[grant] <= 1'b1;
            state                       <= RELAY;
          end
        end
        RELAY: begin
          // Ready is held until the served lane drops valid, so a lane that
          // keeps valid high still sees only one completion.
          if (served_write ? !consumer_write_valid[grant] : !consumer_read_valid[grant]) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_controller.sv
// Directed bench for mem_request_controller (4 lanes, 8-bit address/data).
module tb_mem_request_controller;

  localparam int N = 4;
  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_READ_WAIT  = 2'd1;
  localparam logic [1:0] S_WRITE_WAIT = 2'd2;
  localparam logic [1:0] S_RELAY      = 2'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] consumer_read_valid;
  logic [7:0]   consumer_read_address [N];
  logic [N-1:0] consumer_read_ready;
  logic [7:0]   consumer_read_data [N];
  logic [N-1:0] consumer_write_valid;
  logic [7:0]   consumer_write_address [N];
  logic [7:0]   consumer_write_data [N];
  logic [N-1:0] consumer_write_ready;
  logic         mem_read_valid;
  logic [7:0]   mem_read_address;
  logic         mem_read_ready;
  logic [7:0]   mem_read_data;
  logic         mem_write_valid;
  logic [7:0]   mem_write_address;
  logic [7:0]   mem_write_data;
  logic         mem_write_ready;
  logic [1:0]   debug_state;
  logic [1:0]   debug_rr_ptr;

  // Memory read data: a fixed value when use_fixed, else the inverted address.
  logic         use_fixed;
  logic [7:0]   fixed_data;
  assign mem_read_data = use_fixed ? fixed_data : ~mem_read_address;

  int vectors = 0;
  int miscompares = 0;
  int mem_rd_hs = 0;

  mem_request_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid),
    .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready),
    .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data),
    .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready),
    .debug_state(debug_state),
    .debug_rr_ptr(debug_rr_ptr)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count completed external read handshakes.
  always @(posedge clk) begin
    if (!reset && mem_read_valid && mem_read_ready) mem_rd_hs <= mem_rd_hs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    for (int i = 0; i < N; i++) begin
      consumer_read_address[i]  = '0;
      consumer_write_address[i] = '0;
      consumer_write_data[i]    = '0;
    end
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    use_fixed       = 1'b0;
    fixed_data      = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({consumer_read_ready, consumer_write_ready, mem_read_valid, mem_write_valid} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_ready_valid: got %b expected 0", {consumer_read_ready, consumer_write_ready, mem_read_valid, mem_write_valid});
    end
    vectors++;
    if ({mem_read_address, mem_write_address, mem_write_data} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_addr_data: got %h expected 0", {mem_read_address, mem_write_address, mem_write_data});
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (consumer_read_data[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_read_data[%0d]: got %h expected 00", i, consumer_read_data[i]);
      end
    end
    vectors++;
    if (debug_state !== S_IDLE || debug_rr_ptr !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got state %0d ptr %0d expected 0 0", debug_state, debug_rr_ptr);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (debug_state !== S_IDLE || mem_read_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_request: got state %0d mrv %b expected 0 0", debug_state, mem_read_valid);
    end
  endtask

  task automatic test_lane2_read();
    do_reset();
    consumer_read_valid[2]   = 1'b1;
    consumer_read_address[2] = 8'h15;
    use_fixed  = 1'b1;
    fixed_data = 8'hA7;
    tick();
    vectors++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h15 || consumer_read_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL lane2_request: got mrv %b addr %h rdy %b expected 1 15 0000", mem_read_valid, mem_read_address, consumer_read_ready);
    end
    mem_read_ready = 1'b1;
    tick();
    vectors++;
    if (consumer_read_ready !== 4'b0100 || consumer_read_data[2] !== 8'hA7 || mem_read_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lane2_response: got rdy %b data %h mrv %b expected 0100 a7 0", consumer_read_ready, consumer_read_data[2], mem_read_valid);
    end
    consumer_read_valid[2] = 1'b0;
    mem_read_ready = 1'b0;
    tick();
    vectors++;
    if (consumer_read_ready !== 4'b0000 || debug_state !== S_IDLE || consumer_read_data[2] !== 8'hA7) begin
      miscompares++;
      $display("FAIL lane2_release: got rdy %b state %0d data %h expected 0000 0 a7", consumer_read_ready, debug_state, consumer_read_data[2]);
    end
    vectors++;
    if (debug_rr_ptr !== 2'd3) begin
      miscompares++;
      $display("FAIL lane2_rr_ptr: got %0d expected 3", debug_rr_ptr);
    end
  endtask

  task automatic test_round_robin();
    int order [7] = '{0, 1, 2, 3, 0, 1, 3};
    do_reset();
    mem_read_ready = 1'b1;
    for (int i = 0; i < N; i++) consumer_read_address[i] = 8'h40 + 8'(i);
    consumer_read_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) begin
        vectors++;
        if (debug_rr_ptr !== 2'd0) begin
          miscompares++;
          $display("FAIL rr_wrap: got ptr %0d expected 0", debug_rr_ptr);
        end
        consumer_read_valid = 4'b0001;
      end
      if (k == 5) consumer_read_valid = 4'b1010;
      tick();
      vectors++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== (8'h40 + 8'(order[k]))) begin
        miscompares++;
        $display("FAIL rr_grant_%0d: got mrv %b addr %h expected 1 %h", k, mem_read_valid, mem_read_address, 8'h40 + 8'(order[k]));
      end
      tick();
      vectors++;
      if (consumer_read_ready !== (4'b0001 << order[k]) || consumer_read_data[order[k]] !== ~(8'h40 + 8'(order[k]))) begin
        miscompares++;
        $display("FAIL rr_resp_%0d: got rdy %b data %h expected %b %h", k, consumer_read_ready, consumer_read_data[order[k]], 4'b0001 << order[k], ~(8'h40 + 8'(order[k])));
      end
      consumer_read_valid[order[k]] = 1'b0;
      tick();
      vectors++;
      if (consumer_read_ready !== 4'b0000 || debug_state !== S_IDLE) begin
        miscompares++;
        $display("FAIL rr_idle_%0d: got rdy %b state %0d expected 0000 0", k, consumer_read_ready, debug_state);
      end
    end
  endtask

  task automatic test_read_write_priority();
    do_reset();
    consumer_read_valid[0]    = 1'b1;
    consumer_read_address[0]  = 8'h10;
    consumer_write_valid[0]   = 1'b1;
    consumer_write_address[0] = 8'h20;
    consumer_write_data[0]    = 8'h5C;
    mem_read_ready  = 1'b1;
    mem_write_ready = 1'b1;
    tick();
    vectors++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h10 || mem_write_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_read_first: got mrv %b addr %h mwv %b expected 1 10 0", mem_read_valid, mem_read_address, mem_write_valid);
    end
    tick();
    vectors++;
    if (consumer_read_ready !== 4'b0001 || consumer_write_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rw_read_ready: got rrdy %b wrdy %b expected 0001 0000", consumer_read_ready, consumer_write_ready);
    end
    consumer_read_valid[0] = 1'b0;
    tick();
    vectors++;
    if (debug_state !== S_IDLE || consumer_read_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rw_read_done: got state %0d rrdy %b expected 0 0000", debug_state, consumer_read_ready);
    end
    tick();
    vectors++;
    if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h20 || mem_write_data !== 8'h5C || mem_read_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_write_req: got mwv %b addr %h data %h mrv %b expected 1 20 5c 0", mem_write_valid, mem_write_address, mem_write_data, mem_read_valid);
    end
    tick();
    vectors++;
    if (consumer_write_ready !== 4'b0001 || mem_write_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_write_ready: got wrdy %b mwv %b expected 0001 0", consumer_write_ready, mem_write_valid);
    end
    consumer_write_valid[0] = 1'b0;
    tick();
    vectors++;
    if (consumer_write_ready !== 4'b0000 || debug_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL rw_write_done: got wrdy %b state %0d expected 0000 0", consumer_write_ready, debug_state);
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    consumer_read_valid[1]   = 1'b1;
    consumer_read_address[1] = 8'h33;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h33 || consumer_read_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL stall_cycle_%0d: got mrv %b addr %h rdy %b expected 1 33 0000", c, mem_read_valid, mem_read_address, consumer_read_ready);
      end
    end
    use_fixed      = 1'b1;
    fixed_data     = 8'h3C;
    mem_read_ready = 1'b1;
    tick();
    vectors++;
    if (consumer_read_ready !== 4'b0010 || consumer_read_data[1] !== 8'h3C) begin
      miscompares++;
      $display("FAIL stall_release: got rdy %b data %h expected 0010 3c", consumer_read_ready, consumer_read_data[1]);
    end
    consumer_read_valid[1] = 1'b0;
    mem_read_ready = 1'b0;
    tick();
  endtask

  task automatic test_hold_valid();
    int hs_start;
    do_reset();
    hs_start = mem_rd_hs;
    consumer_read_valid[3]   = 1'b1;
    consumer_read_address[3] = 8'h77;
    mem_read_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (consumer_read_ready !== 4'b1000 || consumer_read_data[3] !== 8'h88) begin
      miscompares++;
      $display("FAIL hold_first_ready: got rdy %b data %h expected 1000 88", consumer_read_ready, consumer_read_data[3]);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (consumer_read_ready !== 4'b1000 || mem_read_valid !== 1'b0 || debug_state !== S_RELAY) begin
        miscompares++;
        $display("FAIL hold_extra_%0d: got rdy %b mrv %b state %0d expected 1000 0 3", c, consumer_read_ready, mem_read_valid, debug_state);
      end
    end
    consumer_read_valid[3] = 1'b0;
    tick();
    tick();
    vectors++;
    if (consumer_read_ready !== 4'b0000 || mem_read_valid !== 1'b0 || debug_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL hold_release: got rdy %b mrv %b state %0d expected 0000 0 0", consumer_read_ready, mem_read_valid, debug_state);
    end
    vectors++;
    if (mem_rd_hs - hs_start !== 1) begin
      miscompares++;
      $display("FAIL hold_single_txn: got %0d memory reads expected 1", mem_rd_hs - hs_start);
    end
    mem_read_ready = 1'b0;
  endtask

  task automatic test_write_drop_valid();
    do_reset();
    consumer_write_valid[1]   = 1'b1;
    consumer_write_address[1] = 8'h66;
    consumer_write_data[1]    = 8'h99;
    tick();
    vectors++;
    if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h66 || mem_write_data !== 8'h99) begin
      miscompares++;
      $display("FAIL drop_write_req: got mwv %b addr %h data %h expected 1 66 99", mem_write_valid, mem_write_address, mem_write_data);
    end
    consumer_write_valid[1] = 1'b0;
    tick();
    vectors++;
    if (mem_write_valid !== 1'b1 || debug_state !== S_WRITE_WAIT) begin
      miscompares++;
      $display("FAIL drop_write_hold: got mwv %b state %0d expected 1 2", mem_write_valid, debug_state);
    end
    mem_write_ready = 1'b1;
    tick();
    vectors++;
    if (consumer_write_ready !== 4'b0010 || mem_write_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_write_ready: got wrdy %b mwv %b expected 0010 0", consumer_write_ready, mem_write_valid);
    end
    mem_write_ready = 1'b0;
    tick();
    vectors++;
    if (consumer_write_ready !== 4'b0000 || debug_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL drop_write_exit: got wrdy %b state %0d expected 0000 0", consumer_write_ready, debug_state);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    consumer_read_valid[0]   = 1'b1;
    consumer_read_address[0] = 8'h01;
    consumer_read_valid[2]   = 1'b1;
    consumer_read_address[2] = 8'h21;
    // Serve lane 0 first so rr_ptr and read data are non-zero before the reset.
    mem_read_ready = 1'b1;
    tick();
    tick();
    consumer_read_valid[0] = 1'b0;
    mem_read_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if (debug_state !== S_READ_WAIT || mem_read_address !== 8'h21 || debug_rr_ptr !== 2'd3) begin
      miscompares++;
      $display("FAIL midflight_setup: got state %0d addr %h ptr %0d expected 1 21 3", debug_state, mem_read_address, debug_rr_ptr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    consumer_read_valid[2] = 1'b0;
    vectors++;
    if (debug_state !== S_IDLE || debug_rr_ptr !== 2'd0 || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 ||
        consumer_read_ready !== 4'b0000 || consumer_read_data[0] !== 8'h00) begin
      miscompares++;
      $display("FAIL midflight_reset: got state %0d ptr %0d mrv %b addr %h rdy %b data0 %h expected 0 0 0 00 0000 00",
               debug_state, debug_rr_ptr, mem_read_valid, mem_read_address, consumer_read_ready, consumer_read_data[0]);
    end
    mem_read_ready = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    tick();
    vectors++;
    if (consumer_read_ready !== 4'b0000 || mem_read_valid !== 1'b0 || debug_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL midflight_stray_ready: got rdy %b mrv %b state %0d expected 0000 0 0", consumer_read_ready, mem_read_valid, debug_state);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_lane2_read();
    test_round_robin();
    test_read_write_priority();
    test_mem_stall();
    test_hold_valid();
    test_write_drop_valid();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_request_controller.md
Name: mem_request_controller

Overview:
- Memory-side responder for the per-thread data-memory request lanes that a compute core drives: per-lane read/write valid+address(+data) in, ready+read data out.
- Arbitrates NUM_CONSUMERS lanes round-robin onto one external memory port with the same valid/ready protocol.
- Sits between the compute cores' data-memory lanes and the data memory.
- One transaction in flight at a time.

Parameters:
- ADDR_BITS, 8, memory address width
- DATA_BITS, 8, memory data width
- NUM_CONSUMERS, 4, number of request lanes (threads); ≥1

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- consumer_read_valid  in  [NUM_CONSUMERS-1:0]  per-lane read request, held until ready
- consumer_read_address  in  [ADDR_BITS-1:0] x NUM_CONSUMERS  read address
- consumer_read_ready  out  [NUM_CONSUMERS-1:0]  read response; data valid while high
- consumer_read_data  out  [DATA_BITS-1:0] x NUM_CONSUMERS  read data
- consumer_write_valid  in  [NUM_CONSUMERS-1:0]  per-lane write request, held until ready
- consumer_write_address  in  [ADDR_BITS-1:0] x NUM_CONSUMERS  write address
- consumer_write_data  in  [DATA_BITS-1:0] x NUM_CONSUMERS  write data
- consumer_write_ready  out  [NUM_CONSUMERS-1:0]  write complete
- mem_read_valid  out  1  external read request
- mem_read_address  out  [ADDR_BITS-1:0]  external read address
- mem_read_ready  in  1  external read data valid
- mem_read_data  in  [DATA_BITS-1:0]  external read data
- mem_write_valid  out  1  external write request
- mem_write_address  out  [ADDR_BITS-1:0]  external write address
- mem_write_data  out  [DATA_BITS-1:0]  external write data
- mem_write_ready  in  1  external write accepted

Behaviour:
- All outputs are registered. Reset (checked at posedge) has priority over everything:
  - state=IDLE, rr_ptr=0.
  - All ready, valid, data and address outputs = 0.
  - Any in-flight transaction is dropped; no ready is issued for it.
- States: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE arbitration:
  - pending[i] = read_valid[i] | write_valid[i].
  - Grant the first pending lane searching rr_ptr, rr_ptr+1, … modulo NUM_CONSUMERS.
  - None pending: stay in IDLE.
  - On grant g: latch g and rr_ptr <= (g+1) mod NUM_CONSUMERS (wraps at NUM_CONSUMERS-1 -> 0).
- Read vs write on the granted lane: read has priority if both are asserted. The write is served in a later grant.
- Read grant:
  - mem_read_valid <= 1; mem_read_address <= lane address.
  - Next state READ_WAIT.
- Write grant:
  - mem_write_valid <= 1; mem_write_address/data <= lane values.
  - Next state WRITE_WAIT.
- READ_WAIT:
  - Hold mem_read_valid/address until mem_read_ready=1.
  - That cycle: mem_read_valid <= 0, consumer_read_data[g] <= mem_read_data, consumer_read_ready[g] <= 1 → RELAY.
- WRITE_WAIT:
  - Same pattern on mem_write_ready.
  - consumer_write_ready[g] <= 1 → RELAY.
- RELAY:
  - Hold ready and data for lane g until that lane's matching valid (read or write, whichever was served) is low.
  - Then ready <= 0 → IDLE.
  - consumer_read_data[g] keeps its value after ready drops, until overwritten.
  - Guarantees exactly one ready per request even if the consumer holds valid for extra cycles. No new grant is made while in RELAY.
- Minimum latency, consumer valid high in IDLE at cycle 0 with mem ready combinationally high:
  - mem valid at cycle 1.
  - consumer ready at cycle 2.
  - Return to IDLE at cycle 3 if the consumer drops valid at cycle 2.
- Only the granted lane's ready can be high; never more than one ready bit high in total.
- mem_read_valid and mem_write_valid are never high together.
- Requests on non-granted lanes stay pending and are untouched; consumers must hold valid and address stable.
- Valid dropped by the consumer during READ_WAIT/WRITE_WAIT:
  - The memory transaction still completes.
  - RELAY sees valid low and exits after one ready cycle.
- NUM_CONSUMERS=1: rr_ptr is constant 0; behaviour otherwise identical.

Test Plan:
- Lane 2 read addr 0x15, memory returns 0xA7 with ready one cycle after request → mem_read_address=0x15; consumer_read_ready=4'b0100 with consumer_read_data[2]=0xA7 exactly one handshake; back to IDLE after lane drops valid.
- All 4 lanes assert read simultaneously, rr_ptr=0, memory ready immediately → service order 0,1,2,3; then rr_ptr=0 again; next simultaneous burst from lanes {1,3} after serving lane 0 alone is served 1 then 3.
- Lane 0 asserts read (0x10) and write (0x20, data 0x5C) together → read served first; write served on a later grant; mem_write_address=0x20, mem_write_data=0x5C; consumer_write_ready[0] pulses once.
- Memory holds mem_read_ready low 5 cycles → mem_read_valid and address stable for all 5 cycles; no consumer ready; ready on cycle after mem_read_ready.
- Consumer holds read_valid 3 extra cycles after ready → ready stays high those cycles; exactly one memory transaction issued; no duplicate grant.
- Reset asserted during READ_WAIT → next cycle all outputs 0, state IDLE, rr_ptr=0; later mem_read_ready pulse while idle produces no consumer ready.
